// File: rtl/exp_pkg.sv
// Shared definitions for the exp core and its downstream result buffer.
// Fixed-point formats: input Q1.14 (16 bits), output Q7.25 (32 bits).
package exp_pkg;

  localparam int WIDTHIN   = 16;
  localparam int WIDTHOUT  = 32;
  localparam int QIN_FRAC  = 14;
  localparam int QOUT_FRAC = 25;

  typedef logic [WIDTHOUT-1:0] q7_25_t;

endpackage : exp_pkg

// File: rtl/exp_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write, combinational read.
// Contents are never reset; validity is tracked by the owning FIFO.
module exp_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : exp_fifo_ram

// File: rtl/exp_result_fifo.sv
// Result buffer between the exp core and its consumer: a small FIFO with
// valid/ready on both sides, occupancy output and a delivered-results counter.
module exp_result_fifo
  import exp_pkg::*;
#(
  parameter int WIDTH = WIDTHOUT,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNTW-1:0]          o_popped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0]   L_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]   L_ONE  = LW'(1);
  localparam logic [AW-1:0]   P_ONE  = AW'(1);
  localparam logic [CNTW-1:0] C_ONE  = CNTW'(1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("exp_result_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CNTW-1:0] r_popped;

  logic            w_push;
  logic            w_pop;
  logic [LW-1:0]   w_level_nxt;

  // Flow control depends only on the level register, never on i_ready,
  // so a full buffer refuses a push even when a pop happens that cycle.
  assign o_ready = (r_level != L_FULL);
  assign o_valid = (r_level != '0);
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + L_ONE;
      2'b01:   w_level_nxt = r_level - L_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_popped <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
        r_popped <= r_popped + C_ONE;
      end
    end
  end

  exp_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_data)
  );

  assign o_level  = r_level;
  assign o_popped = r_popped;

endmodule : exp_result_fifo

// File: tb/tb_exp_result_fifo.sv
// Directed bench for exp_result_fifo: reset, push/pop, full, simultaneous
// push+pop with pointer wrap, stalled upstream, and asynchronous reset.
module tb_exp_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [2:0]       o_level;
  logic [CNTW-1:0]  o_popped;

  int total = 0;
  int bad   = 0;

  logic [31:0] seq [12];
  logic [31:0] dq  [5];

  exp_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .i_ready  (i_ready),
    .o_level  (o_level),
    .o_popped (o_popped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [2:0] lvl, input logic [15:0] pop);
    chk({tag, ".valid"},  32'(o_valid),  32'(v));
    chk({tag, ".ready"},  32'(o_ready),  32'(r));
    chk({tag, ".level"},  32'(o_level),  32'(lvl));
    chk({tag, ".popped"}, 32'(o_popped), 32'(pop));
  endtask

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    step(); step();
    chk_state("rst_held", 1'b0, 1'b1, 3'd0, 16'd0);
    reset = 1'b1;
    step();
    chk_state("rst_rel", 1'b0, 1'b1, 3'd0, 16'd0);

    // single push, one-cycle latency, then pop
    i_valid = 1'b1; i_data = 32'h056FC2A2;
    step();
    i_valid = 1'b0;
    chk_state("push1", 1'b1, 1'b1, 3'd1, 16'd0);
    chk("push1.data", o_data, 32'h056FC2A2);
    step();
    chk_state("pop1", 1'b0, 1'b1, 3'd0, 16'd1);

    // fill to full, fifth push ignored, drain in order
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 32'h02000000 + 32'(i);
      step();
    end
    chk_state("full", 1'b1, 1'b0, 3'd4, 16'd1);
    i_data = 32'h0FFFFFFF;
    step();
    chk("full.ignore.level", 32'(o_level), 32'd4);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.data", i), o_data, 32'h02000000 + 32'(i));
      step();
    end
    chk_state("drained", 1'b0, 1'b1, 3'd0, 16'd5);

    // full with push and pop requested together: pop only
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 32'hA0000000 + 32'(i);
      step();
    end
    i_data  = 32'hDEADBEEF;
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    chk("fullpp.level", 32'(o_level), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fullpp%0d.data", i), o_data, 32'hA0000000 + 32'(i));
      step();
    end
    chk_state("fullpp.end", 1'b0, 1'b1, 3'd0, 16'd9);

    // level 2, ten simultaneous push+pop across pointer wrap
    seq[0] = 32'hB0000000; seq[1] = 32'hB0000001;
    for (int i = 0; i < 10; i++) seq[i+2] = 32'hC0000000 + 32'(i * 7);
    i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = seq[i];
      step();
    end
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_data = seq[i+2];
      step();
      chk($sformatf("pp%0d.level", i), 32'(o_level), 32'd2);
      chk($sformatf("pp%0d.data", i), o_data, seq[i+1]);
    end
    i_valid = 1'b0;
    chk("pp.tail0", o_data, seq[10]);
    step();
    chk("pp.tail1", o_data, seq[11]);
    step();
    chk_state("pp.end", 1'b0, 1'b1, 3'd0, 16'd21);

    // upstream holds a result while the buffer is full for 30 cycles
    for (int i = 0; i < 4; i++) dq[i] = 32'h05600000 + 32'(i * 16);
    dq[4] = 32'h056FC2A2;
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = dq[i];
      step();
    end
    i_data = dq[4];
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("stall%0d.level", i), 32'(o_level), 32'd4);
    end
    chk("stall.ready", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    step();
    chk("unstall1.level", 32'(o_level), 32'd3);
    chk("unstall1.data", o_data, dq[1]);
    step();
    i_valid = 1'b0;
    chk("unstall2.level", 32'(o_level), 32'd3);
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("unstall.d%0d", i), o_data, dq[i]);
      step();
    end
    chk_state("unstall.end", 1'b0, 1'b1, 3'd0, 16'd26);

    // asynchronous reset between edges with three entries buffered
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_data = 32'h33000000 + 32'(i);
      step();
    end
    i_valid = 1'b0;
    chk("pre_arst.level", 32'(o_level), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_state("arst", 1'b0, 1'b1, 3'd0, 16'd0);
    step();
    reset = 1'b1;
    i_valid = 1'b1; i_data = 32'h44444444;
    step();
    i_valid = 1'b0;
    chk_state("post_arst", 1'b1, 1'b1, 3'd1, 16'd0);
    chk("post_arst.data", o_data, 32'h44444444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_exp_result_fifo
